// File: rtl/adaptive_slicer.sv
// Multi-channel FFE slicer with a 2-stage pipeline and per-channel threshold adaptation
// that steers each channel's ones-density toward 50%.
module adaptive_slicer #(
  parameter int unsigned numChannels        = 16,
  parameter int unsigned inputBitwidth      = 10,
  parameter int unsigned thresholdBitwidth  = 10,
  parameter int unsigned confidenceBitwidth = 8,
  parameter int unsigned windowLog2         = 8,
  parameter int unsigned deadband           = 4,
  parameter int unsigned stepBitwidth       = 4
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [numChannels-1:0][inputBitwidth-1:0]         codes,
  input  logic                                              in_valid,
  input  logic [1:0]                                        mode,
  input  logic [numChannels-1:0][thresholdBitwidth-1:0]     new_thresh,
  input  logic                                              thresh_load,
  input  logic [stepBitwidth-1:0]                           step,
  output logic [numChannels-1:0]                            bit_out,
  output logic [numChannels-1:0][confidenceBitwidth-1:0]    confidence,
  output logic                                              out_valid,
  output logic [numChannels-1:0][thresholdBitwidth-1:0]     thresh_cur,
  output logic                                              win_done
);

  localparam int unsigned DW = ((inputBitwidth > thresholdBitwidth) ? inputBitwidth : thresholdBitwidth) + 1;
  localparam int unsigned AW = ((thresholdBitwidth > stepBitwidth) ? thresholdBitwidth : stepBitwidth) + 2;
  localparam int unsigned CW = windowLog2 + 1;

  localparam logic [confidenceBitwidth-1:0] CMAX     = '1;
  localparam logic [CW-1:0]                 WIN_LAST = CW'((2 ** windowLog2) - 1);
  localparam logic [CW-1:0]                 ONES_HI  = CW'((2 ** (windowLog2 - 1)) + deadband);
  localparam logic [CW-1:0]                 ONES_LO  = CW'((2 ** (windowLog2 - 1)) - deadband);
  localparam logic signed [AW-1:0]          TMAX     = AW'((2 ** (thresholdBitwidth - 1)) - 1);
  localparam logic signed [AW-1:0]          TMIN     = -(AW'(2 ** (thresholdBitwidth - 1)));

  typedef enum logic [1:0] {IDLE, ACCUM, UPDATE} state_t;

  state_t                                           state;
  logic [numChannels-1:0][inputBitwidth-1:0]        code_s1;
  logic                                             valid_s1;
  logic [CW-1:0]                                    win_cnt;
  logic [numChannels-1:0][CW-1:0]                   ones_cnt;
  logic [numChannels-1:0]                           bit_c;
  logic [numChannels-1:0][confidenceBitwidth-1:0]   conf_c;
  logic [numChannels-1:0][thresholdBitwidth-1:0]    thr_step;
  logic                                             keep_c;

  // Per-channel compare (S2) and saturating threshold step for the UPDATE cycle
  for (genvar g = 0; g < numChannels; g++) begin : g_ch
    logic signed [DW-1:0] code_x, thr_x, diff, mag;
    logic signed [AW-1:0] thr_w, stp_w, sum;

    always_comb begin
      code_x    = DW'($signed(code_s1[g]));
      thr_x     = (mode == 2'd2) ? '0 : DW'($signed(thresh_cur[g]));
      diff      = code_x - thr_x;
      mag       = diff[DW-1] ? -diff : diff;
      bit_c[g]  = !diff[DW-1] && (diff != '0);
      conf_c[g] = (mag > DW'(CMAX)) ? CMAX : mag[confidenceBitwidth-1:0];
    end

    always_comb begin
      thr_w = AW'($signed(thresh_cur[g]));
      stp_w = AW'(step);
      if (ones_cnt[g] > ONES_HI)      sum = thr_w + stp_w;
      else if (ones_cnt[g] < ONES_LO) sum = thr_w - stp_w;
      else                            sum = thr_w;
      if (sum > TMAX)      thr_step[g] = thresholdBitwidth'(TMAX);
      else if (sum < TMIN) thr_step[g] = thresholdBitwidth'(TMIN);
      else                 thr_step[g] = sum[thresholdBitwidth-1:0];
    end
  end

  // A sample seen during UPDATE opens the next window unless a load or mode exit restarts it
  assign keep_c = out_valid && !thresh_load && (mode == 2'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      code_s1    <= '0;
      valid_s1   <= 1'b0;
      bit_out    <= '0;
      confidence <= '0;
      out_valid  <= 1'b0;
      thresh_cur <= '0;
      win_done   <= 1'b0;
      win_cnt    <= '0;
      ones_cnt   <= '0;
    end else begin
      code_s1   <= codes;
      valid_s1  <= in_valid;
      out_valid <= valid_s1;
      win_done  <= 1'b0;
      if (valid_s1) begin
        bit_out    <= bit_c;
        confidence <= conf_c;
      end
      if (thresh_load) thresh_cur <= new_thresh;

      case (state)
        IDLE: begin
          win_cnt  <= '0;
          ones_cnt <= '0;
          if (mode == 2'd1) state <= ACCUM;
        end
        ACCUM: begin
          if (mode != 2'd1) begin
            state    <= IDLE;
            win_cnt  <= '0;
            ones_cnt <= '0;
          end else if (thresh_load) begin
            win_cnt  <= '0;
            ones_cnt <= '0;
          end else if (out_valid) begin
            win_cnt <= win_cnt + CW'(1);
            for (int i = 0; i < numChannels; i++) begin
              ones_cnt[i] <= ones_cnt[i] + CW'(bit_out[i]);
            end
            if (win_cnt == WIN_LAST) begin
              state    <= UPDATE;
              win_done <= 1'b1;
            end
          end
        end
        UPDATE: begin
          if (!thresh_load) thresh_cur <= thr_step;
          win_cnt <= CW'(keep_c);
          for (int i = 0; i < numChannels; i++) begin
            ones_cnt[i] <= CW'(keep_c && bit_out[i]);
          end
          state <= (mode == 2'd1) ? ACCUM : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adaptive_slicer.sv
// Randomized and directed bench for adaptive_slicer against a per-cycle behavioural model.
module tb_adaptive_slicer;

  localparam int unsigned NCH = 16;
  localparam int unsigned IW  = 10;
  localparam int unsigned TW  = 10;
  localparam int unsigned CFW = 8;
  localparam int unsigned WL  = 8;
  localparam int          DB  = 4;
  localparam int unsigned SW  = 4;
  localparam int          WIN = 2 ** WL;
  localparam int          H   = WIN / 2;

  logic                           clk = 1'b0;
  logic                           rst;
  logic [NCH-1:0][IW-1:0]         codes;
  logic                           in_valid;
  logic [1:0]                     mode;
  logic [NCH-1:0][TW-1:0]         new_thresh;
  logic                           thresh_load;
  logic [SW-1:0]                  step;
  logic [NCH-1:0]                 bit_out;
  logic [NCH-1:0][CFW-1:0]        confidence;
  logic                           out_valid;
  logic [NCH-1:0][TW-1:0]         thresh_cur;
  logic                           win_done;

  adaptive_slicer dut (
    .clk(clk), .rst(rst), .codes(codes), .in_valid(in_valid), .mode(mode),
    .new_thresh(new_thresh), .thresh_load(thresh_load), .step(step),
    .bit_out(bit_out), .confidence(confidence), .out_valid(out_valid),
    .thresh_cur(thresh_cur), .win_done(win_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: decisions, thresholds and window bookkeeping as plain integers
  int m_thr[NCH], m_ones[NCH], m_conf[NCH], s1_code[NCH], bias[NCH];
  bit m_dec[NCH];
  bit m_ov, m_wd, m_adapt, s1_vld;
  int m_cnt;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic int clamp_thr(input int t);
    if (t > 511)  return 511;
    if (t < -512) return -512;
    return t;
  endfunction

  task automatic model_step();
    int n_thr[NCH];
    int d, thr;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_thr[i] = 0; m_ones[i] = 0; m_conf[i] = 0; m_dec[i] = 0; s1_code[i] = 0;
      end
      m_ov = 0; m_wd = 0; m_adapt = 0; s1_vld = 0; m_cnt = 0;
      return;
    end
    // threshold: load beats the adaptation step
    for (int i = 0; i < NCH; i++) begin
      n_thr[i] = m_thr[i];
      if (thresh_load) n_thr[i] = $signed(new_thresh[i]);
      else if (m_wd) begin
        if (m_ones[i] > H + DB)      n_thr[i] = clamp_thr(m_thr[i] + int'(step));
        else if (m_ones[i] < H - DB) n_thr[i] = clamp_thr(m_thr[i] - int'(step));
      end
    end
    // window bookkeeping over the decisions currently presented
    if (!m_adapt || mode != 2'd1 || thresh_load || m_wd) begin
      m_cnt = 0;
      for (int i = 0; i < NCH; i++) m_ones[i] = 0;
    end
    if (m_adapt && mode == 2'd1 && !thresh_load && m_ov) begin
      m_cnt++;
      for (int i = 0; i < NCH; i++) m_ones[i] += int'(m_dec[i]);
    end
    m_wd = m_adapt && mode == 2'd1 && !thresh_load && !m_wd && (m_cnt == WIN);
    m_adapt = (mode == 2'd1);
    // decisions for the sample captured one cycle earlier, against today's thresholds
    if (s1_vld) begin
      for (int i = 0; i < NCH; i++) begin
        thr = (mode == 2'd2) ? 0 : m_thr[i];
        d = s1_code[i] - thr;
        m_dec[i]  = (d > 0);
        m_conf[i] = (d < 0) ? -d : d;
        if (m_conf[i] > 255) m_conf[i] = 255;
      end
    end
    m_ov = s1_vld;
    for (int i = 0; i < NCH; i++) m_thr[i] = n_thr[i];
    s1_vld = in_valid;
    for (int i = 0; i < NCH; i++) s1_code[i] = $signed(codes[i]);
  endtask

  task automatic compare_all();
    logic [NCH-1:0]          e_bit;
    logic [NCH-1:0][CFW-1:0] e_conf;
    logic [NCH-1:0][TW-1:0]  e_thr;
    for (int i = 0; i < NCH; i++) begin
      e_bit[i]  = m_dec[i];
      e_conf[i] = CFW'(m_conf[i]);
      e_thr[i]  = TW'(m_thr[i]);
    end
    check("out_valid", 256'(out_valid), 256'(m_ov));
    check("win_done", 256'(win_done), 256'(m_wd));
    check("bit_out", 256'(bit_out), 256'(e_bit));
    check("confidence", 256'(confidence), 256'(e_conf));
    check("thresh_cur", 256'(thresh_cur), 256'(e_thr));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic set_all_codes(input int v);
    for (int i = 0; i < NCH; i++) codes[i] = IW'(v);
  endtask

  task automatic load_all(input int v);
    for (int i = 0; i < NCH; i++) new_thresh[i] = TW'(v);
    thresh_load = 1'b1;
    tick();
    thresh_load = 1'b0;
  endtask

  task automatic wait_win(input int max_cycles, input string tag);
    bit seen = 0;
    for (int n = 0; n < max_cycles && !seen; n++) begin
      tick();
      seen = win_done;
    end
    check(tag, 256'(seen), 256'(1));
  endtask

  task automatic drive_biased();
    int v;
    for (int i = 0; i < NCH; i++) begin
      v = bias[i] + int'($urandom_range(0, 128)) - 64;
      codes[i] = IW'(clamp_thr(v));
    end
  endtask

  initial begin
    int last_wd, period, tv;
    rst = 1'b1; codes = '0; in_valid = 1'b0; mode = 2'd0;
    new_thresh = '0; thresh_load = 1'b0; step = '0;
    m_wd = 0; m_ov = 0; m_adapt = 0; s1_vld = 0; m_cnt = 0;
    for (int i = 0; i < NCH; i++) begin
      m_thr[i] = 0; m_ones[i] = 0; m_conf[i] = 0; m_dec[i] = 0; s1_code[i] = 0;
    end
    repeat (3) tick();
    check("reset_outputs", 256'({bit_out, confidence, out_valid, win_done}), 256'(0));
    rst = 1'b0;
    tick();

    // basic polarity: +5 / -5 / tie, then hold while invalid
    for (int i = 0; i < NCH; i++) codes[i] = IW'($urandom);
    codes[0] = IW'(5); codes[1] = IW'(-5); codes[2] = IW'(0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("t1_bits", 256'(bit_out[2:0]), 256'(3'b001));
    check("t1_conf", 256'({confidence[2], confidence[1], confidence[0]}), 256'({8'd0, 8'd5, 8'd5}));
    check("t1_valid", 256'(out_valid), 256'(1));
    tick();
    check("t1_hold", 256'({out_valid, bit_out[2:0], confidence[1]}), 256'({1'b0, 3'b001, 8'd5}));

    // confidence saturation at the extreme of the range
    load_all(-512);
    codes[0] = IW'(511); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("t2_sat", 256'({bit_out[0], confidence[0]}), 256'({1'b1, 8'd255}));

    // non-adaptive modes with random codes, validity and loads
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NCH; i++) begin
        codes[i] = IW'($urandom);
        new_thresh[i] = TW'($urandom);
      end
      in_valid = 1'($urandom);
      mode = ($urandom_range(0, 2) == 0) ? 2'd2 : ((n % 2 == 0) ? 2'd0 : 2'd3);
      thresh_load = ($urandom_range(0, 30) == 0);
      tick();
    end
    thresh_load = 1'b0;

    // constant +20 code converges from 0 and dithers 19/20
    mode = 2'd1; step = SW'(1); in_valid = 1'b1;
    set_all_codes(20);
    load_all(0);
    for (int w = 0; w < 24; w++) wait_win(WIN + 8, "t3_win_timeout");
    tv = $signed(thresh_cur[0]);
    check("t3_dither", 256'((tv == 19) || (tv == 20)), 256'(1));

    // alternating validity: windows count valid samples only
    last_wd = -1; period = 0;
    for (int n = 0; n < 1600; n++) begin
      in_valid = n[0];
      tick();
      if (win_done) begin
        if (last_wd >= 0) period = cyc - last_wd;
        last_wd = cyc;
      end
    end
    check("t4_period", 256'(period), 256'(2 * WIN));

    // load coincident with UPDATE
    in_valid = 1'b1;
    wait_win(WIN + 8, "t5_win_timeout");
    load_all(7);
    check("t5_load", 256'(thresh_cur[0]), 256'(TW'(7)));
    wait_win(WIN + 8, "t5_next_win");

    // reset part-way through a window
    repeat (100) tick();
    rst = 1'b1;
    tick();
    check("t6_reset", 256'({bit_out, confidence, out_valid, win_done, thresh_cur}), 256'(0));
    rst = 1'b0;
    wait_win(WIN + 8, "t6_first_win");

    // randomized adaptation: per-channel offsets, sparse validity, mode exits, loads
    for (int i = 0; i < NCH; i++) bias[i] = int'($urandom_range(0, 200)) - 100;
    for (int n = 0; n < 4000; n++) begin
      drive_biased();
      in_valid = ($urandom_range(0, 3) != 0);
      if (n % 250 == 0) mode = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
      if (win_done) step = SW'($urandom);
      for (int i = 0; i < NCH; i++) new_thresh[i] = TW'(int'($urandom_range(0, 100)) - 50);
      thresh_load = ($urandom_range(0, 700) == 0) || (win_done && $urandom_range(0, 5) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
